// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM: fetch -> decode -> regread -> execute -> [memory] -> writeback.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_COUNT_EN.
module instruction_sequencer #(
    parameter logic [3:0] OP_LOAD     = 4'b1000,
    parameter logic [3:0] OP_STORE    = 4'b1001,
    parameter logic [3:0] OP_JUMP     = 4'b1100,
    parameter logic [3:0] OP_HALT     = 4'b1111,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        en_fetch,
    output logic        en_decode,
    output logic        en_regread,
    output logic        en_alu,
    output logic        en_regwrite,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [3:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_REGREAD   = 4'd3,
        S_EXECUTE   = 4'd4,
        S_MEMORY    = 4'd5,
        S_WRITEBACK = 4'd6,
        S_HALT      = 4'd7,
        S_FAULT     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_JUMP  = 2'd3
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    // Anything not recognised as LOAD/STORE/JUMP runs down the ALU path.
    function automatic cls_e classify(input logic [3:0] op);
        if (op == OP_LOAD)       return CLS_LOAD;
        else if (op == OP_STORE) return CLS_STORE;
        else if (op == OP_JUMP)  return CLS_JUMP;
        else                     return CLS_ALU;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ALU;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)              state_d = S_DECODE;
                else if (wcnt_q == WCNT_LAST) state_d = S_FAULT;
                else                        wcnt_d  = wcnt_q + WCNT_W'(1);
            end
            S_DECODE: begin
                state_d = S_REGREAD;
            end
            S_REGREAD: begin
                cls_d   = classify(opcode);
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (cls_q == CLS_LOAD || cls_q == CLS_STORE) state_d = S_MEMORY;
                else                                         state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) state_d = run ? S_FETCH : S_IDLE;
                    else                    state_d = S_WRITEBACK;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_WRITEBACK: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        // Every fresh handshake (including STORE -> FETCH back-to-back) starts a new timeout window.
        if ((state_d == S_FETCH  && state_q != S_FETCH) ||
            (state_d == S_MEMORY && state_q != S_MEMORY))
            wcnt_d = '0;
    end

    always_comb begin
        mem_req     = (state_q == S_FETCH) || (state_q == S_MEMORY);
        mem_we      = (state_q == S_MEMORY) && (cls_q == CLS_STORE);
        en_fetch    = (state_q == S_FETCH);
        en_decode   = (state_q == S_DECODE);
        en_regread  = (state_q == S_REGREAD);
        en_alu      = (state_q == S_EXECUTE);
        en_regwrite = (state_q == S_WRITEBACK) && (cls_q != CLS_JUMP);
        pc_load     = (state_q == S_WRITEBACK) && (cls_q == CLS_JUMP);
        // A STORE retires in MEMORY on the acknowledge cycle, so its PC step rides on mem_ready.
        pc_inc      = ((state_q == S_WRITEBACK) && (cls_q != CLS_JUMP)) ||
                      ((state_q == S_MEMORY) && (cls_q == CLS_STORE) && mem_ready);
        state       = state_q;
        halted      = (state_q == S_HALT);
        fault       = (state_q == S_FAULT);
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic        retire;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        retire = (state_q == S_WRITEBACK) ||
                 ((state_q == S_MEMORY) && (cls_q == CLS_STORE) && mem_ready);
        cnt_d  = cnt_q;
        if (retire) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: stimulus pushes expected retire records,
// a negedge monitor pops and checks them whenever the DUT retires (pc_inc or pc_load).
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  opcode;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, en_fetch, en_decode, en_regread, en_alu;
    logic        en_regwrite, pc_inc, pc_load, halted, fault;
    logic [3:0]  state;
    logic [15:0] instr_count;

`ifdef SEQ_INSTR_COUNT_EN
    localparam int EXP_CNT = 3;
`else
    localparam int EXP_CNT = 0;
`endif

    instruction_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .en_fetch(en_fetch), .en_decode(en_decode),
        .en_regread(en_regread), .en_alu(en_alu), .en_regwrite(en_regwrite),
        .pc_inc(pc_inc), .pc_load(pc_load), .state(state), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] st;
        logic       rw;
        logic       inc;
        logic       ld;
        int         lat;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acknowledges after wait_fetch / wait_mem cycles spent in the current state.
    int         wait_fetch = 0;
    int         wait_mem   = 0;
    int         wcnt       = 0;
    logic [3:0] st_seen    = 4'd0;
    always @(posedge clock) begin
        #1;
        if (state !== st_seen) begin
            st_seen = state;
            wcnt    = 0;
        end else begin
            wcnt++;
        end
        mem_ready = mem_req && (wcnt >= ((state == 4'd1) ? wait_fetch : wait_mem));
    end

    // Monitor
    int         cyc = 0, fetch_start = 0, retires = 0;
    int         rw_cyc = 0, inc_cyc = 0, ld_cyc = 0, we_cyc = 0, we_bad = 0;
    logic [3:0] last_st = 4'd0;
    always @(negedge clock) begin : mon
        exp_t e;
        cyc++;
        if (state == 4'd1 && last_st != 4'd1) fetch_start = cyc;
        if (en_regwrite) rw_cyc++;
        if (pc_inc)      inc_cyc++;
        if (pc_load)     ld_cyc++;
        if (mem_we)      we_cyc++;
        if (mem_we && state != 4'd5) we_bad++;
        if (pc_inc || pc_load) begin
            retires++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL retire_unexpected: retire in state %0d, expected none", state);
            end else begin
                e = q.pop_front();
                chk("retire_state",    32'(state),       32'(e.st));
                chk("retire_regwrite", 32'(en_regwrite), 32'(e.rw));
                chk("retire_pc_inc",   32'(pc_inc),      32'(e.inc));
                chk("retire_pc_load",  32'(pc_load),     32'(e.ld));
                chk("retire_latency",  32'(cyc - fetch_start + 1), 32'(e.lat));
            end
        end
        last_st = state;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        @(negedge clock);
        while (state !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (state !== s) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting for state %0d, at state %0d", name, s, state);
        end
    endtask

    task automatic push_exp(input logic [3:0] st, input logic rw, input logic inc,
                            input logic ld, input int lat);
        exp_t e;
        e.st = st; e.rw = rw; e.inc = inc; e.ld = ld; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic run_one(input logic [3:0] op, input logic [3:0] st, input logic rw,
                           input logic inc, input logic ld, input int lat, input string name);
        push_exp(st, rw, inc, ld, lat);
        tick;
        opcode = op;
        run    = 1'b1;
        wait_state(4'd1, 20, name);
        tick;
        run = 1'b0;
        wait_state(4'd0, 200, name);
    endtask

    task automatic async_reset;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seq[7];
        int r0, i0, l0, w0, n, stay;
        seq = '{0, 1, 2, 3, 4, 6, 1};
        reset = 1'b1; run = 1'b0; opcode = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({mem_req, mem_we, en_fetch, en_decode, en_regread, en_alu,
                             en_regwrite, pc_inc, pc_load, halted, fault}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;

        // Back-to-back ALU instructions, zero-wait memory
        push_exp(4'd6, 1'b1, 1'b1, 1'b0, 5);
        push_exp(4'd6, 1'b1, 1'b1, 1'b0, 5);
        r0 = rw_cyc; i0 = inc_cyc;
        tick;
        opcode = 4'b0001;
        run    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk($sformatf("alu_seq%0d", i), 32'(state), 32'(seq[i]));
        end
        tick;
        run = 1'b0;
        wait_state(4'd0, 50, "alu_idle");
        chk("alu_regwrite_cycles", 32'(rw_cyc - r0), 32'd2);
        chk("alu_pc_inc_cycles",   32'(inc_cyc - i0), 32'd2);

        // LOAD: 3 waits in FETCH, 2 in MEMORY -> 11 cycles
        wait_fetch = 3; wait_mem = 2;
        r0 = rw_cyc; w0 = we_cyc;
        run_one(4'b1000, 4'd6, 1'b1, 1'b1, 1'b0, 11, "load");
        chk("load_mem_we",   32'(we_cyc - w0), 32'd0);
        chk("load_regwrite", 32'(rw_cyc - r0), 32'd1);

        // STORE: write only in MEMORY, pc_inc on the ack cycle
        wait_fetch = 0; wait_mem = 0;
        r0 = rw_cyc; w0 = we_cyc; i0 = inc_cyc;
        run_one(4'b1001, 4'd5, 1'b0, 1'b1, 1'b0, 5, "store");
        chk("store_mem_we",   32'(we_cyc - w0), 32'd1);
        chk("store_regwrite", 32'(rw_cyc - r0), 32'd0);
        chk("store_pc_inc",   32'(inc_cyc - i0), 32'd1);
        chk("mem_we_outside_memory", 32'(we_bad), 32'd0);

        // STORE with 2 memory waits -> 7 cycles
        wait_mem = 2;
        run_one(4'b1001, 4'd5, 1'b0, 1'b1, 1'b0, 7, "store_wait");
        wait_mem = 0;

        // JUMP and unknown opcode
        l0 = ld_cyc; i0 = inc_cyc;
        run_one(4'b1100, 4'd6, 1'b0, 1'b0, 1'b1, 5, "jump");
        chk("jump_pc_load", 32'(ld_cyc - l0), 32'd1);
        chk("jump_pc_inc",  32'(inc_cyc - i0), 32'd0);
        run_one(4'b1010, 4'd6, 1'b1, 1'b1, 1'b0, 5, "unknown_op");

        // HALT: sticky through run toggling, cleared by reset
        tick;
        opcode = 4'b1111;
        run    = 1'b1;
        wait_state(4'd7, 20, "halt_enter");
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick;
            run = i[0];
            @(negedge clock);
            chk($sformatf("halt_hold%0d", i), 32'(state), 32'd7);
        end
        chk("halt_strobes", 32'({mem_req, en_fetch, en_decode, en_regread, en_alu,
                                 en_regwrite, pc_inc, pc_load}), 32'd0);
        run = 1'b0;
        async_reset;
        chk("halt_rst_state",  32'(state), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        tick;
        reset = 1'b0;

        // FETCH timeout: 15 un-acked cycles then FAULT
        wait_fetch = 1000;
        tick;
        opcode = 4'b0001;
        run    = 1'b1;
        wait_state(4'd1, 20, "fault_fetch");
        tick;
        run  = 1'b0;
        stay = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (state == 4'd1) stay++;
        end
        chk("fault_fetch_cycles", 32'(stay), 32'd14);
        @(negedge clock);
        chk("fault_state",   32'(state), 32'd8);
        chk("fault_flag",    32'(fault), 32'd1);
        chk("fault_mem_req", 32'(mem_req), 32'd0);
        tick;
        run = 1'b1;
        repeat (3) @(negedge clock);
        chk("fault_sticky", 32'({state, fault}), 32'({4'd8, 1'b1}));
        chk("fault_strobes", 32'({mem_req, en_fetch, en_decode, en_regread, en_alu,
                                  en_regwrite, pc_inc, pc_load}), 32'd0);
        run = 1'b0;
        async_reset;
        chk("fault_rst", 32'({state, fault}), 32'd0);
        tick;
        reset = 1'b0;

        // Ready on the last allowed cycle is accepted
        wait_fetch = 14;
        run_one(4'b0001, 4'd6, 1'b1, 1'b1, 1'b0, 19, "ready_last");
        chk("ready_last_no_fault", 32'(fault), 32'd0);

        // Async reset mid-MEMORY
        wait_fetch = 0; wait_mem = 1000;
        tick;
        opcode = 4'b1000;
        run    = 1'b1;
        wait_state(4'd5, 30, "mid_mem");
        tick;
        run = 1'b0;
        async_reset;
        chk("midmem_mem_req", 32'(mem_req), 32'd0);
        chk("midmem_state",   32'(state), 32'd0);
        tick;
        reset   = 1'b0;
        wait_mem = 0;

        // Three retires back-to-back, then stop
        async_reset;
        tick;
        reset = 1'b0;
        chk("cnt_after_reset", 32'(instr_count), 32'd0);
        for (int i = 0; i < 3; i++) push_exp(4'd6, 1'b1, 1'b1, 1'b0, 5);
        r0 = retires;
        opcode = 4'b0001;
        run    = 1'b1;
        n = 0;
        while (retires < r0 + 2 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("cnt_two_retired", 32'(retires - r0), 32'd2);
        tick;
        run = 1'b0;
        wait_state(4'd0, 50, "cnt_idle");
        chk("cnt_retires", 32'(retires - r0), 32'd3);
        chk("cnt_value",   32'(instr_count), 32'(EXP_CNT));
        chk("cnt_state",   32'(state), 32'd0);

        repeat (2) @(negedge clock);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control FSM that sequences the instruction datapath: memory fetch → instruction_decoder → register-file read → ALU → optional memory access → write-back/PC update.
- Drives the decoder's `enable` input via `en_decode`, and consumes the decoder's registered `opcode` output.
- Owns the instruction-memory request handshake and raises a sticky fault on memory timeout.

Parameters:
- OP_LOAD, 4'b1000, opcode class needing memory read, then write-back
- OP_STORE, 4'b1001, opcode class needing memory write, no write-back
- OP_JUMP, 4'b1100, opcode loading PC instead of incrementing; no register write
- OP_HALT, 4'b1111, opcode stopping execution
- MEM_TIMEOUT, 15, max consecutive un-acknowledged request cycles before fault (≥2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  4  registered opcode from instruction_decoder
- mem_ready  in  1  memory acknowledge; may be high in the same cycle as mem_req
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (STORE), 0 = read
- en_fetch  out  1  instruction-register load strobe
- en_decode  out  1  instruction_decoder enable
- en_regread  out  1  register-file read strobe
- en_alu  out  1  ALU enable
- en_regwrite  out  1  register-file write strobe
- pc_inc  out  1  PC increment pulse
- pc_load  out  1  PC load pulse (JUMP)
- state  out  4  current state encoding
- halted  out  1  HALT reached (sticky)
- fault  out  1  memory timeout (sticky)
- instr_count  out  16  retired-instruction count (see optional feature)

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, REGREAD=3, EXECUTE=4, MEMORY=5, WRITEBACK=6, HALT=7, FAULT=8.
- All outputs are decoded from registered state. Single-cycle strobes are high for exactly one cycle.
- Reset value of every output is 0, and state=IDLE. Reset is async and may occur in any state, including mid-handshake. Reset drops mem_req immediately and clears halted, fault, the wait counter and instr_count.
- IDLE: run=1 → FETCH; otherwise stay.
- FETCH: mem_req=1, mem_we=0, en_fetch=1 for every cycle in FETCH.
  - mem_ready=1 → DECODE.
  - The instruction register captures on the mem_ready cycle.
- DECODE: en_decode=1 → REGREAD. The decoder's opcode is valid from REGREAD onward.
- REGREAD: en_regread=1. Sample opcode into an internal class register.
  - opcode==OP_HALT → HALT.
  - Otherwise → EXECUTE.
- EXECUTE: en_alu=1.
  - Class LOAD or STORE → MEMORY.
  - Otherwise → WRITEBACK.
- MEMORY: mem_req=1, mem_we=(class==STORE).
  - mem_ready=1 and LOAD → WRITEBACK.
  - mem_ready=1 and STORE → assert pc_inc in this cycle and retire; next state is FETCH if run=1, else IDLE.
- WRITEBACK: retire.
  - en_regwrite=1 unless class JUMP.
  - pc_load=1 if JUMP, else pc_inc=1.
  - Next state is FETCH if run=1, else IDLE.
- HALT: halted=1, no strobes. Exit only via reset; run is ignored.
- Wait counter, width $clog2(MEM_TIMEOUT):
  - Cleared on entry to FETCH or MEMORY.
  - Increments each waiting cycle with mem_ready=0.
  - counter==MEM_TIMEOUT-1 with mem_ready=0 → FAULT. This is exactly MEM_TIMEOUT un-acknowledged cycles.
  - mem_ready on the last allowed cycle is accepted.
- FAULT: fault=1, mem_req=0, all strobes 0. Exit only via reset.
- Latency with zero-wait memory:
  - ALU/JUMP instruction: 5 cycles.
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - Each memory wait cycle adds 1.
- run deasserted mid-instruction does not abort; the instruction completes first.
- Unknown opcodes execute as ALU class.

Optional Feature:
- Macro: SEQ_INSTR_COUNT_EN.
- Defined:
  - instr_count increments by 1 on each retire (WRITEBACK, or STORE completion in MEMORY).
  - Wraps 16'hFFFF→0.
  - HALT does not count.
- Undefined: instr_count is tied to 16'h0000 and the counter logic is absent.

Test Plan:
- Reset, then run=1, opcode=4'b0001, mem_ready=1 → state sequence 0,1,2,3,4,6,1; en_regwrite and pc_inc each high exactly 1 cycle per instruction.
- LOAD (4'b1000) with 3 wait cycles in FETCH and 2 in MEMORY → 11 cycles FETCH-entry to retire; mem_we=0 throughout; en_regwrite in WRITEBACK.
- STORE (4'b1001) → mem_we=1 only in MEMORY; en_regwrite never asserted; pc_inc on the mem_ready cycle.
- JUMP (4'b1100) → pc_load=1 and pc_inc=0 in WRITEBACK. HALT (4'b1111) → state=7, halted=1, stays through run toggling; reset clears.
- mem_ready held 0 in FETCH → fault=1 and state=8 after exactly 15 cycles; a variant with ready on cycle 15 proceeds to DECODE. Async reset mid-MEMORY → mem_req=0 immediately, state=0.
- With SEQ_INSTR_COUNT_EN: preload scenario retiring 3 instructions, then run=0 → instr_count=3 and state=IDLE. Without the macro: instr_count=0.
